// File: rtl/alu.sv
// Registered 16-operation ALU with carry/zero/negative/overflow flags.
// One-cycle latency; Enable=0 holds all outputs; asynchronous active-low reset clears them.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  input  logic [3:0]       Opcode,
  output logic [WIDTH-1:0] Results,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             OF
);

  typedef enum logic [3:0] {
    OP_PASS = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011,
    OP_OR   = 4'b0100, OP_XOR = 4'b0101, OP_NOT = 4'b0110, OP_NOR = 4'b0111,
    OP_SHL  = 4'b1000, OP_SHR = 4'b1001, OP_SAR = 4'b1010, OP_ROL = 4'b1011,
    OP_ROR  = 4'b1100, OP_INC = 4'b1101, OP_DEC = 4'b1110, OP_MUL = 4'b1111
  } op_e;

  logic [WIDTH-1:0]   res_d, res_q;
  logic               cf_d, cf_q, of_d, of_q;
  logic               zf_q, nf_q;
  logic [3:0]         amt;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH:0]     shl_ext, shr_ext, sar_ext;
  logic [2*WIDTH-1:0] rol_ext, ror_ext, prod;

  assign amt = Data_B[3:0];
  // INC/DEC reuse the adder and subtractor with a constant second operand.
  assign b_eff = (Opcode == OP_INC || Opcode == OP_DEC) ? WIDTH'(1) : Data_B;

  always_comb begin
    sum     = {1'b0, Data_A} + {1'b0, b_eff};
    diff    = {1'b0, Data_A} - {1'b0, b_eff};
    // A guard bit beside the operand catches the last bit shifted out.
    shl_ext = {1'b0, Data_A} << amt;
    shr_ext = {Data_A, 1'b0} >> amt;
    sar_ext = $signed({Data_A, 1'b0}) >>> amt;
    rol_ext = {Data_A, Data_A} << amt;
    ror_ext = {Data_A, Data_A} >> amt;
    prod    = {{WIDTH{1'b0}}, Data_A} * {{WIDTH{1'b0}}, Data_B};

    res_d = Data_A;
    cf_d  = 1'b0;
    of_d  = 1'b0;
    case (op_e'(Opcode))
      OP_PASS: res_d = Data_A;
      OP_ADD, OP_INC: begin
        res_d = sum[WIDTH-1:0];
        cf_d  = sum[WIDTH];
        of_d  = (Data_A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != Data_A[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        res_d = diff[WIDTH-1:0];
        cf_d  = diff[WIDTH];
        of_d  = (Data_A[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != Data_A[WIDTH-1]);
      end
      OP_AND:  res_d = Data_A & Data_B;
      OP_OR:   res_d = Data_A | Data_B;
      OP_XOR:  res_d = Data_A ^ Data_B;
      OP_NOT:  res_d = ~Data_A;
      OP_NOR:  res_d = ~(Data_A | Data_B);
      OP_SHL: begin
        res_d = shl_ext[WIDTH-1:0];
        cf_d  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_d = shr_ext[WIDTH:1];
        cf_d  = shr_ext[0];
      end
      OP_SAR: begin
        res_d = sar_ext[WIDTH:1];
        cf_d  = sar_ext[0];
      end
      OP_ROL: begin
        res_d = rol_ext[2*WIDTH-1:WIDTH];
        cf_d  = (amt != 4'd0) && rol_ext[WIDTH];
      end
      OP_ROR: begin
        res_d = ror_ext[WIDTH-1:0];
        cf_d  = (amt != 4'd0) && ror_ext[WIDTH-1];
      end
      OP_MUL: begin
        res_d = prod[WIDTH-1:0];
        cf_d  = |prod[2*WIDTH-1:WIDTH];
      end
      default: res_d = Data_A;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_q <= '0;
      cf_q  <= 1'b0;
      zf_q  <= 1'b0;
      nf_q  <= 1'b0;
      of_q  <= 1'b0;
    end else if (Enable) begin
      res_q <= res_d;
      cf_q  <= cf_d;
      zf_q  <= (res_d == '0);
      nf_q  <= res_d[WIDTH-1];
      of_q  <= of_d;
    end
  end

  assign Results = res_q;
  assign CF      = cf_q;
  assign ZF      = zf_q;
  assign NF      = nf_q;
  assign OF      = of_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset, every opcode, wrap/overflow corners, enable hold.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data_a = '0;
  logic [15:0] data_b = '0;
  logic [3:0]  opcode = '0;
  logic [15:0] results;
  logic        cf, zf, nf, of;

  int vectors = 0;
  int miscompares = 0;

  alu #(.WIDTH(16)) dut (
    .CLK(clk), .RST(rst_n), .Enable(enable),
    .Data_A(data_a), .Data_B(data_b), .Opcode(opcode),
    .Results(results), .CF(cf), .ZF(zf), .NF(nf), .OF(of)
  );

  always #5 clk = ~clk;

  // Observed/expected packed as {Results, CF, ZF, NF, OF}.
  task automatic check(input string tag, input logic [15:0] exp_res, input logic [3:0] exp_czno);
    logic [19:0] obs, expv;
    obs  = {results, cf, zf, nf, of};
    expv = {exp_res, exp_czno};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed res=%h czno=%b, expected res=%h czno=%b",
             tag, obs[19:4], obs[3:0], expv[19:4], expv[3:0]);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp_res, input logic [3:0] exp_czno);
    @(negedge clk);
    enable = 1'b1;
    opcode = op;
    data_a = a;
    data_b = b;
    @(posedge clk);
    #1;
    check(tag, exp_res, exp_czno);
  endtask

  initial begin
    #2;
    check("reset_state", 16'h0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    //                 op       A         B         Results   CZNO
    run("pass",      4'b0000, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
    run("add",       4'b0001, 16'd6464, 16'd4646, 16'h2B66, 4'b0000);
    run("add_wrap",  4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100);
    run("add_ovf",   4'b0001, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011);
    run("sub_borrow",4'b0010, 16'd4646, 16'd6464, 16'hF8E6, 4'b1010);
    run("sub_ovf",   4'b0010, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
    run("and",       4'b0011, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    run("or",        4'b0100, 16'hF0F0, 16'h0F00, 16'hFFF0, 4'b0010);
    run("xor_zero",  4'b0101, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100);
    run("not",       4'b0110, 16'h00FF, 16'h1234, 16'hFF00, 4'b0010);
    run("nor",       4'b0111, 16'h0000, 16'h0000, 16'hFFFF, 4'b0010);
    run("shl1",      4'b1000, 16'h8001, 16'h0001, 16'h0002, 4'b1000);
    run("shl0",      4'b1000, 16'h8001, 16'h0000, 16'h8001, 4'b0010);
    run("shr1",      4'b1001, 16'h0003, 16'h0001, 16'h0001, 4'b1000);
    run("shr15",     4'b1001, 16'h8000, 16'h000F, 16'h0001, 4'b0000);
    run("sar4",      4'b1010, 16'h8000, 16'h0004, 16'hF800, 4'b0010);
    run("sar1",      4'b1010, 16'h8001, 16'h0001, 16'hC000, 4'b1010);
    run("rol4",      4'b1011, 16'h8001, 16'h0004, 16'h0018, 4'b0000);
    run("rol1",      4'b1011, 16'h8000, 16'hFFF1, 16'h0001, 4'b1000);
    run("ror1",      4'b1100, 16'h0001, 16'h0001, 16'h8000, 4'b1010);
    run("ror0",      4'b1100, 16'h8001, 16'h0010, 16'h8001, 4'b0010);
    run("inc_wrap",  4'b1101, 16'hFFFF, 16'h1234, 16'h0000, 4'b1100);
    run("inc_ovf",   4'b1101, 16'h7FFF, 16'h0000, 16'h8000, 4'b0011);
    run("dec_wrap",  4'b1110, 16'h0000, 16'h0000, 16'hFFFF, 4'b1010);
    run("dec_ovf",   4'b1110, 16'h8000, 16'h5555, 16'h7FFF, 4'b0001);
    run("mul",       4'b1111, 16'h0003, 16'h0005, 16'h000F, 4'b0000);
    run("mul_hi",    4'b1111, 16'h0100, 16'h0100, 16'h0000, 4'b1100);

    // Enable low: inputs churn, outputs must hold the mul_hi result.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      enable = 1'b0;
      opcode = 4'(i + 1);
      data_a = 16'h1111 * 16'(i + 1);
      data_b = 16'h0101;
      @(posedge clk);
      #1;
      check("hold", 16'h0000, 4'b1100);
    end
    @(negedge clk);
    enable = 1'b1;
    opcode = 4'b0000;
    data_a = 16'hBEEF;
    #1;
    check("hold_pre_edge", 16'h0000, 4'b1100);
    @(posedge clk);
    #1;
    check("enable_resume", 16'hBEEF, 4'b0010);

    // Reset asserted between edges with a capture pending.
    @(negedge clk);
    opcode = 4'b0001;
    data_a = 16'h0001;
    data_b = 16'h0001;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_hold", 16'h0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    check("post_reset_add", 16'h0002, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
